// File: rtl/xbus_decoder_fsm.sv
// Registered xbus address decoder / response router: one-hot chip select per transaction,
// slave ack/rdata mux back to the master, error on unmapped addresses. XBUS_TIMEOUT_EN adds a BUSY watchdog.
module xbus_decoder_fsm #(
    parameter int                          NSLAVES = 4,
    parameter int                          ADDR_W  = 32,
    parameter int                          DATA_W  = 32,
    parameter logic [NSLAVES*ADDR_W-1:0]   BASE    = {32'h00020000, 32'h00010000, 32'h80000000, 32'h00001000},
    parameter logic [NSLAVES*ADDR_W-1:0]   MASK    = {32'hFFFFF000, 32'hFFFFFFFC, 32'hFFFF0000, 32'hFFFFFF00},
    parameter int                          TIMEOUT = 255
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         xbus_as,
    input  logic [ADDR_W-1:0]            xbus_addr,
    output logic [NSLAVES-1:0]           xbus_cs,
    input  logic [NSLAVES-1:0]           xbus_slv_ack,
    input  logic [NSLAVES*DATA_W-1:0]    xbus_slv_rdata,
    output logic                         xbus_ack,
    output logic                         xbus_err,
    output logic [DATA_W-1:0]            xbus_rdata,
    output logic [ADDR_W-1:0]            xbus_err_addr
);

    if (TIMEOUT < 2) begin : g_timeout_range
        $error("xbus_decoder_fsm: TIMEOUT must be at least 2");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t                state, state_next;
    logic [NSLAVES-1:0]    cs_next;
    logic                  ack_next, err_next;
    logic [DATA_W-1:0]     rdata_next;
    logic [ADDR_W-1:0]     err_addr_next;

    logic [NSLAVES-1:0]    hit_onehot;
    logic                  hit;
    logic                  sel_ack;
    logic [DATA_W-1:0]     sel_rdata;
    logic                  wd_expired;

    // Scan downwards so the lowest matching window is the last one written and wins.
    always_comb begin
        hit_onehot = '0;
        for (int i = NSLAVES - 1; i >= 0; i--) begin
            if ((xbus_addr & MASK[i*ADDR_W +: ADDR_W]) == BASE[i*ADDR_W +: ADDR_W])
                hit_onehot = NSLAVES'(1) << i;
        end
    end

    assign hit     = |hit_onehot;
    assign sel_ack = |(xbus_slv_ack & xbus_cs);

    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NSLAVES; i++) begin
            if (xbus_cs[i])
                sel_rdata = sel_rdata | xbus_slv_rdata[i*DATA_W +: DATA_W];
        end
    end

`ifdef XBUS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT);

    logic [CNT_W-1:0] wd_cnt, wd_cnt_next;

    assign wd_expired = (wd_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wd_cnt <= '0;
        else        wd_cnt <= wd_cnt_next;
    end
`else
    assign wd_expired = 1'b0;
`endif

    // NOTE: every output of this block gets a default before the case, so no path can infer a latch.
    always_comb begin
        state_next    = state;
        cs_next       = xbus_cs;
        ack_next      = 1'b0;
        err_next      = xbus_err;
        rdata_next    = xbus_rdata;
        err_addr_next = xbus_err_addr;
`ifdef XBUS_TIMEOUT_EN
        wd_cnt_next   = wd_cnt;
`endif
        case (state)
            S_IDLE: begin
                if (xbus_as) begin
                    if (hit) begin
                        cs_next    = hit_onehot;
                        state_next = S_BUSY;
`ifdef XBUS_TIMEOUT_EN
                        wd_cnt_next = '0;
`endif
                    end else begin
                        ack_next      = 1'b1;
                        err_next      = 1'b1;
                        rdata_next    = '0;
                        err_addr_next = xbus_addr;
                        state_next    = S_DONE;
                    end
                end
            end
            S_BUSY: begin
                // A slave ack on the expiry cycle still completes without error.
                if (sel_ack) begin
                    cs_next    = '0;
                    ack_next   = 1'b1;
                    err_next   = 1'b0;
                    rdata_next = sel_rdata;
                    state_next = S_DONE;
                end else if (wd_expired) begin
                    cs_next       = '0;
                    ack_next      = 1'b1;
                    err_next      = 1'b1;
                    rdata_next    = '0;
                    err_addr_next = xbus_addr;
                    state_next    = S_DONE;
                end else begin
`ifdef XBUS_TIMEOUT_EN
                    wd_cnt_next = wd_cnt + CNT_W'(1);
`endif
                end
            end
            S_DONE: begin
                if (!xbus_as)
                    state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            xbus_cs       <= '0;
            xbus_ack      <= 1'b0;
            xbus_err      <= 1'b0;
            xbus_rdata    <= '0;
            xbus_err_addr <= '0;
        end else begin
            state         <= state_next;
            xbus_cs       <= cs_next;
            xbus_ack      <= ack_next;
            xbus_err      <= err_next;
            xbus_rdata    <= rdata_next;
            xbus_err_addr <= err_addr_next;
        end
    end

endmodule

// File: tb/tb_xbus_decoder_fsm.sv
// Self-checking bench for xbus_decoder_fsm: directed test-plan cases plus randomized
// transactions checked against a transaction-level model of the decode and timing rules.
module tb_xbus_decoder_fsm;

    localparam int NS = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;
`ifdef XBUS_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    localparam logic [NS*AW-1:0] BASE_P = {32'h00020000, 32'h00010000, 32'h80000000, 32'h00001000};
    localparam logic [NS*AW-1:0] MASK_P = {32'hFFFFF000, 32'hFFFFFFFC, 32'hFFFF0000, 32'hFFFFFF00};

    // Windows written out by slave index, independent of the packed parameter layout.
    logic [31:0] win_base [NS] = '{32'h00001000, 32'h80000000, 32'h00010000, 32'h00020000};
    logic [31:0] win_mask [NS] = '{32'hFFFFFF00, 32'hFFFF0000, 32'hFFFFFFFC, 32'hFFFFF000};

    logic              clk;
    logic              rst_n;
    logic              xbus_as;
    logic [AW-1:0]     xbus_addr;
    logic [NS-1:0]     xbus_cs;
    logic [NS-1:0]     xbus_slv_ack;
    logic [NS*DW-1:0]  xbus_slv_rdata;
    logic              xbus_ack;
    logic              xbus_err;
    logic [DW-1:0]     xbus_rdata;
    logic [AW-1:0]     xbus_err_addr;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_err, exp_rdata, exp_err_addr;

    xbus_decoder_fsm #(
        .NSLAVES (NS),
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .BASE    (BASE_P),
        .MASK    (MASK_P),
        .TIMEOUT (TO)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .xbus_as        (xbus_as),
        .xbus_addr      (xbus_addr),
        .xbus_cs        (xbus_cs),
        .xbus_slv_ack   (xbus_slv_ack),
        .xbus_slv_rdata (xbus_slv_rdata),
        .xbus_ack       (xbus_ack),
        .xbus_err       (xbus_err),
        .xbus_rdata     (xbus_rdata),
        .xbus_err_addr  (xbus_err_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, got, want, $time);
        end
    endtask

    function automatic int find_slave(input logic [31:0] a);
        for (int i = 0; i < NS; i++)
            if ((a & win_mask[i]) == win_base[i]) return i;
        return -1;
    endfunction

    task automatic check_held(input string tag);
        check({tag, ".err"},      {31'b0, xbus_err}, exp_err);
        check({tag, ".rdata"},    xbus_rdata,        exp_rdata);
        check({tag, ".err_addr"}, xbus_err_addr,     exp_err_addr);
    endtask

    // One master transaction. ack_at: BUSY cycle (1-based) on which the selected slave acks, 0 = never.
    // spur: 0 no foreign acks, 1 random foreign acks, 2 all foreign acks high. hold: extra as-high cycles after ack.
    task automatic run_txn(input logic [31:0] addr, input int ack_at, input logic [31:0] data,
                           input int spur, input int hold);
        int          sel;
        int          busy_len;
        bit          acked;
        logic [31:0] exp_cs;
        sel = find_slave(addr);
        acked = 1'b0;
        if (sel < 0) begin
            busy_len = 0;
        end else if (ack_at > 0 && (!TO_EN || ack_at <= TO)) begin
            busy_len = ack_at;
            acked    = 1'b1;
        end else if (TO_EN) begin
            busy_len = TO;
        end else begin
            $display("FAIL run_txn: unacked hit without watchdog at addr %h", addr);
            $fatal(1);
        end
        for (int k = 0; k <= busy_len + hold + 2; k++) begin
            @(negedge clk);
            xbus_as   = (k <= busy_len + hold);
            xbus_addr = addr;
            for (int i = 0; i < NS; i++) begin
                xbus_slv_rdata[i*DW +: DW] = $urandom;
                if (i == sel) begin
                    xbus_slv_ack[i] = (ack_at > 0 && k == ack_at);
                    if (k == ack_at) xbus_slv_rdata[i*DW +: DW] = data;
                end else begin
                    xbus_slv_ack[i] = (spur == 2) ? 1'b1 : (spur == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
                end
            end
            @(posedge clk);
            #1;
            exp_cs = (sel >= 0 && k < busy_len) ? (32'd1 << sel) : 32'd0;
            check("cs", {28'b0, xbus_cs}, exp_cs);
            check("ack", {31'b0, xbus_ack}, (k == busy_len) ? 32'd1 : 32'd0);
            if (k == busy_len) begin
                if (acked) begin
                    exp_err   = 32'd0;
                    exp_rdata = data;
                end else begin
                    exp_err      = 32'd1;
                    exp_rdata    = 32'd0;
                    exp_err_addr = addr;
                end
                check_held("done");
            end
        end
        xbus_slv_ack = '0;
        check_held("hold");
    endtask

    initial begin
        logic [31:0] a;
        int          s;
        rst_n          = 1'b0;
        xbus_as        = 1'b0;
        xbus_addr      = '0;
        xbus_slv_ack   = '0;
        xbus_slv_rdata = '0;
        exp_err        = 32'd0;
        exp_rdata      = 32'd0;
        exp_err_addr   = 32'd0;

        repeat (3) @(negedge clk);
        check("reset.cs", {28'b0, xbus_cs}, 32'd0);
        check("reset.ack", {31'b0, xbus_ack}, 32'd0);
        check_held("reset");
        rst_n = 1'b1;

        run_txn(32'h80000010, 3, 32'hDEADBEEF, 0, 0);
        run_txn(32'h00000500, 0, 32'h0, 1, 0);
        run_txn(32'h00001004, 4, 32'h12345678, 2, 0);
        run_txn(32'h00020ABC, 1, 32'hCAFEF00D, 0, 5);
        run_txn(32'h00001100, 0, 32'h0, 0, 0);
        run_txn(32'h00010004, 0, 32'h0, 0, 1);
        run_txn(32'h00010003, 2, 32'hA5A5A5A5, 1, 0);
        run_txn(32'h8000FFFF, 5, 32'h0BADC0DE, 1, 0);
        run_txn(32'h7FFFFFFF, 0, 32'h0, 2, 0);

        if (TO_EN) begin
            run_txn(32'h00010000, 0, 32'h0, 1, 0);
            run_txn(32'h00010000, TO, 32'h55AA33CC, 0, 0);
            run_txn(32'h00010000, TO + 1, 32'h11111111, 0, 0);
            run_txn(32'h00010000, TO - 1, 32'h22222222, 2, 0);
        end

        // Reset in the middle of a BUSY phase.
        @(negedge clk);
        xbus_as   = 1'b1;
        xbus_addr = 32'h80000020;
        @(posedge clk);
        #1;
        check("rstbusy.cs_before", {28'b0, xbus_cs}, 32'h2);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        exp_err      = 32'd0;
        exp_rdata    = 32'd0;
        exp_err_addr = 32'd0;
        check("rstbusy.cs", {28'b0, xbus_cs}, 32'd0);
        check("rstbusy.ack", {31'b0, xbus_ack}, 32'd0);
        check_held("rstbusy");
        xbus_as = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rstbusy.cs_after", {28'b0, xbus_cs}, 32'd0);
        check("rstbusy.ack_after", {31'b0, xbus_ack}, 32'd0);
        run_txn(32'h80000044, 2, 32'hFEEDFACE, 0, 0);

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 1) == 1) begin
                s = $urandom_range(0, NS - 1);
                a = win_base[s] | ($urandom & ~win_mask[s]);
            end else begin
                a = $urandom;
            end
            run_txn(a, TO_EN ? $urandom_range(0, TO + 2) : $urandom_range(1, 6),
                    $urandom, $urandom_range(0, 2), $urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
